// File: rtl/self_correcting_counter_ctrl.sv
// Command-driven sequencer for one modulo-(MAX_COUNT+1) counter.
// It decodes START/STOP/LOAD commands, drives the counter enable and load
// strobe, and forces the counter back to zero for HOLDOFF cycles whenever
// its value is seen outside 0..MAX_COUNT.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | counter parked, commands accepted
// S_RUN     | counter enabled, commands accepted
// S_LOAD    | one-cycle synchronous load of the captured value
// S_RECOVER | HOLDOFF cycles of load-to-zero after an illegal value
module self_correcting_counter_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 9,
    parameter int HOLDOFF   = 2,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             wrap_pulse,
    output logic             load_err,
    input  logic             clear_err,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count,
    output logic             running
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_COUNT);
    localparam logic [HW-1:0]    HOLD_INIT = HW'(HOLDOFF - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LOAD,
        S_RECOVER
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ret_run;
    logic          ret_run_nxt;
    logic [HW-1:0] hold;
    logic          illegal;
    logic          accept;
    logic          rec_entry;
    logic          load_go;
    logic          data_ok;

    // Range check only matters where the counter is free to drift.
    assign illegal = ((state == S_IDLE) || (state == S_RUN)) && (cnt_value > MAX_V);
    assign accept  = cmd_valid && cmd_ready;
    assign data_ok = (cmd_data <= MAX_V);

    // Next-state decode and the combinational counter controls.
    always_comb begin
        state_nxt   = state;
        ret_run_nxt = ret_run;
        rec_entry   = 1'b0;
        load_go     = 1'b0;
        cmd_ready   = 1'b0;
        cnt_en      = 1'b0;
        cnt_load    = 1'b0;
        running     = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !illegal;
                if (illegal) begin
                    state_nxt   = S_RECOVER;
                    ret_run_nxt = 1'b0;
                    rec_entry   = 1'b1;
                end else if (accept) begin
                    if (cmd_op == OP_START) begin
                        state_nxt = S_RUN;
                    end else if (cmd_op == OP_LOAD) begin
                        state_nxt   = S_LOAD;
                        ret_run_nxt = 1'b0;
                        load_go     = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_en    = 1'b1;
                running   = 1'b1;
                cmd_ready = !illegal;
                // An illegal value outranks any command offered alongside it.
                if (illegal) begin
                    state_nxt   = S_RECOVER;
                    ret_run_nxt = 1'b1;
                    rec_entry   = 1'b1;
                end else if (accept) begin
                    if (cmd_op == OP_STOP) begin
                        state_nxt = S_IDLE;
                    end else if (cmd_op == OP_LOAD) begin
                        state_nxt   = S_LOAD;
                        ret_run_nxt = 1'b1;
                        load_go     = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                cnt_load  = 1'b1;
                running   = ret_run;
                state_nxt = ret_run ? S_RUN : S_IDLE;
            end
            S_RECOVER: begin
                cnt_load = 1'b1;
                running  = ret_run;
                if (hold == '0) begin
                    state_nxt = ret_run ? S_RUN : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, return flag and holdoff down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ret_run <= 1'b0;
            hold    <= '0;
        end else begin
            state   <= state_nxt;
            ret_run <= ret_run_nxt;
            if (rec_entry) begin
                hold <= HOLD_INIT;
            end else if ((state == S_RECOVER) && (hold != '0)) begin
                hold <= hold - 1'b1;
            end
        end
    end

    // Load value and strobes; the load value reads zero outside a LOAD cycle,
    // which is also what RECOVER needs to drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_load_val <= '0;
            load_err     <= 1'b0;
            wrap_pulse   <= 1'b0;
        end else begin
            cnt_load_val <= (load_go && data_ok) ? cmd_data : '0;
            load_err     <= load_go && !data_ok;
            wrap_pulse   <= cnt_en && (cnt_value == MAX_V);
        end
    end

    // Sticky error flag and saturating recovery count; a new recovery beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else if (rec_entry) begin
            err_flag <= 1'b1;
            if (clear_err) begin
                err_count <= ERR_W'(1);
            end else if (err_count != ERR_MAX) begin
                err_count <= err_count + 1'b1;
            end
        end else if (clear_err) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end
    end

endmodule

// File: tb/tb_self_correcting_counter_ctrl.sv
// Bench for self_correcting_counter_ctrl: a behavioural counter closes the
// loop, directed scenarios push expected output values tagged with the cycle
// they must appear in, and a monitor compares them 1 ns after each edge.
module tb_self_correcting_counter_ctrl;

    localparam int F_READY = 0;
    localparam int F_EN    = 1;
    localparam int F_LOAD  = 2;
    localparam int F_LVAL  = 3;
    localparam int F_WRAP  = 4;
    localparam int F_LERR  = 5;
    localparam int F_EFLAG = 6;
    localparam int F_ECNT  = 7;
    localparam int F_RUN   = 8;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = OP_NOP;
    logic [3:0] cmd_data = 4'd0;
    logic       clear_err = 1'b0;
    logic [3:0] cnt_value;
    logic [3:0] cnt_model = 4'd0;
    logic       force_on = 1'b0;
    logic [3:0] force_val = 4'd13;

    logic       cmd_ready;
    logic       cnt_en;
    logic       cnt_load;
    logic [3:0] cnt_load_val;
    logic       wrap_pulse;
    logic       load_err;
    logic       err_flag;
    logic [7:0] err_count;
    logic       running;

    typedef struct {
        int    cyc;
        int    f;
        int    v;
        string tag;
    } sb_t;

    sb_t q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    self_correcting_counter_ctrl #(
        .WIDTH(4), .MAX_COUNT(9), .HOLDOFF(2), .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cnt_value(cnt_value), .cnt_en(cnt_en), .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val), .wrap_pulse(wrap_pulse),
        .load_err(load_err), .clear_err(clear_err),
        .err_flag(err_flag), .err_count(err_count), .running(running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter as the controller assumes it: load beats enable, wraps 9 -> 0.
    always @(posedge clk) begin
        if (rst) cnt_model <= 4'd0;
        else if (cnt_load) cnt_model <= cnt_load_val;
        else if (cnt_en) cnt_model <= (cnt_model == 4'd9) ? 4'd0 : cnt_model + 4'd1;
    end

    assign cnt_value = force_on ? force_val : cnt_model;

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int obs(input int f);
        case (f)
            F_READY: return int'(cmd_ready);
            F_EN:    return int'(cnt_en);
            F_LOAD:  return int'(cnt_load);
            F_LVAL:  return int'(cnt_load_val);
            F_WRAP:  return int'(wrap_pulse);
            F_LERR:  return int'(load_err);
            F_EFLAG: return int'(err_flag);
            F_ECNT:  return int'(err_count);
            F_RUN:   return int'(running);
            default: return -1;
        endcase
    endfunction

    task automatic expect_at(input int dc, input string tag, input int f, input int v);
        sb_t e;
        e.cyc = cyc + dc;
        e.f   = f;
        e.v   = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic expect_zero(input int dc, input string tag);
        expect_at(dc, {tag, "_en"},   F_EN,    0);
        expect_at(dc, {tag, "_ld"},   F_LOAD,  0);
        expect_at(dc, {tag, "_lval"}, F_LVAL,  0);
        expect_at(dc, {tag, "_wrap"}, F_WRAP,  0);
        expect_at(dc, {tag, "_lerr"}, F_LERR,  0);
        expect_at(dc, {tag, "_eflg"}, F_EFLAG, 0);
        expect_at(dc, {tag, "_ecnt"}, F_ECNT,  0);
        expect_at(dc, {tag, "_run"},  F_RUN,   0);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
    endtask

    task automatic bus_idle();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 4'd0;
    endtask

    // Scoreboard monitor: compare every entry due in the cycle just begun.
    always begin
        @(posedge clk);
        #1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                chk(q[i].tag, obs(q[i].f), q[i].v);
                q.delete(i);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        @(negedge clk);
        @(negedge clk);
        expect_zero(1, "rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // START, then a full lap from 0: one wrap, the cycle after value 9.
        send(OP_START, 4'd0);
        expect_at(1, "start_en",  F_EN,  1);
        expect_at(1, "start_run", F_RUN, 1);
        for (int d = 2; d <= 12; d++) expect_at(d, "lap_wrap", F_WRAP, (d == 11) ? 1 : 0);
        expect_at(11, "lap_eflag", F_EFLAG, 0);
        @(negedge clk);
        bus_idle();
        repeat (12) @(negedge clk);

        // LOAD 5 while running, then five enabled cycles to the next wrap.
        send(OP_LOAD, 4'd5);
        expect_at(1, "ld5_load",  F_LOAD,  1);
        expect_at(1, "ld5_val",   F_LVAL,  5);
        expect_at(1, "ld5_ready", F_READY, 0);
        expect_at(1, "ld5_en",    F_EN,    0);
        expect_at(1, "ld5_run",   F_RUN,   1);
        expect_at(2, "ld5_resume", F_EN,   1);
        expect_at(2, "ld5_ldoff", F_LOAD,  0);
        expect_at(6, "ld5_nowrap", F_WRAP, 0);
        expect_at(7, "ld5_wrap",  F_WRAP,  1);
        @(negedge clk);
        bus_idle();
        repeat (7) @(negedge clk);

        // STOP, then an out-of-range LOAD from IDLE.
        send(OP_STOP, 4'd0);
        expect_at(1, "stop_en", F_EN, 0);
        @(negedge clk);
        send(OP_LOAD, 4'd12);
        expect_at(1, "ld12_lerr", F_LERR, 1);
        expect_at(1, "ld12_val",  F_LVAL, 0);
        expect_at(1, "ld12_load", F_LOAD, 1);
        expect_at(1, "ld12_run",  F_RUN,  0);
        expect_at(2, "ld12_lerr_off", F_LERR, 0);
        expect_at(2, "ld12_idle_en",  F_EN,   0);
        expect_at(2, "ld12_idle_ld",  F_LOAD, 0);
        @(negedge clk);
        bus_idle();
        repeat (3) @(negedge clk);

        // Illegal value in RUN: ready drops at once, two zero-load cycles.
        send(OP_START, 4'd0);
        @(negedge clk);
        bus_idle();
        force_on = 1'b1;
        #1;
        chk("ill_ready_drop", int'(cmd_ready), 0);
        expect_at(1, "rec_ld1",   F_LOAD,  1);
        expect_at(1, "rec_val1",  F_LVAL,  0);
        expect_at(1, "rec_en1",   F_EN,    0);
        expect_at(1, "rec_run1",  F_RUN,   1);
        expect_at(1, "rec_eflag", F_EFLAG, 1);
        expect_at(1, "rec_ecnt",  F_ECNT,  1);
        expect_at(2, "rec_ld2",   F_LOAD,  1);
        expect_at(2, "rec_val2",  F_LVAL,  0);
        expect_at(3, "rec_back_en",  F_EN,   1);
        expect_at(3, "rec_back_ld",  F_LOAD, 0);
        expect_at(3, "rec_back_run", F_RUN,  1);
        @(negedge clk);
        force_on = 1'b0;
        repeat (2) @(negedge clk);

        // Recoveries 2..256: the count must stick at 255.
        for (int i = 2; i <= 256; i++) begin
            force_on = 1'b1;
            if (i >= 254) expect_at(1, "sat_ecnt", F_ECNT, (i > 255) ? 255 : i);
            @(negedge clk);
            force_on = 1'b0;
            repeat (2) @(negedge clk);
        end

        // clear_err alone, then clear_err on a recovery-entry cycle.
        clear_err = 1'b1;
        expect_at(1, "clr_ecnt",  F_ECNT,  0);
        expect_at(1, "clr_eflag", F_EFLAG, 0);
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
        force_on  = 1'b1;
        clear_err = 1'b1;
        expect_at(1, "clrrec_ecnt",  F_ECNT,  1);
        expect_at(1, "clrrec_eflag", F_EFLAG, 1);
        @(negedge clk);
        force_on  = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of RECOVER, then restart.
        force_on = 1'b1;
        @(negedge clk);
        force_on = 1'b0;
        rst = 1'b1;
        expect_zero(1, "rstrec");
        @(negedge clk);
        rst = 1'b0;
        send(OP_START, 4'd0);
        expect_at(1, "rstrec_start_en",  F_EN,  1);
        expect_at(1, "rstrec_start_run", F_RUN, 1);
        @(negedge clk);
        bus_idle();
        @(negedge clk);

        // Reset in the middle of LOAD, then restart.
        send(OP_LOAD, 4'd3);
        expect_at(1, "rstld_val", F_LVAL, 3);
        @(negedge clk);
        bus_idle();
        rst = 1'b1;
        expect_zero(1, "rstld");
        @(negedge clk);
        rst = 1'b0;
        send(OP_START, 4'd0);
        expect_at(1, "rstld_start_en", F_EN,    1);
        expect_at(1, "rstld_ready",    F_READY, 1);
        @(negedge clk);
        bus_idle();
        repeat (3) @(negedge clk);

        chk("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/self_correcting_counter_ctrl.md
Name: self_correcting_counter_ctrl

Overview:
- Command-driven controller that sequences one modulo-(MAX_COUNT+1) self-correcting counter in the counter subsystem.
- Accepts START/STOP/LOAD commands over a valid/ready handshake and drives the counter's enable and synchronous load.
- Watches the counter's value and runs a recovery sequence when the value leaves the legal range.
- Keeps a sticky error flag and a saturating error count for the status path.

Parameters:
- WIDTH, 4, counter width in bits.
- MAX_COUNT, 9, highest legal count; legal range is 0..MAX_COUNT, and MAX_COUNT < 2^WIDTH.
- HOLDOFF, 2, cycles spent in RECOVER (>=1).
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts command this cycle.
- cmd_op  in  2  00 NOP, 01 START, 10 STOP, 11 LOAD.
- cmd_data  in  WIDTH  load value for LOAD.
- cnt_value  in  WIDTH  current counter output.
- cnt_en  out  1  counter increment enable.
- cnt_load  out  1  synchronous load strobe to counter.
- cnt_load_val  out  WIDTH  value loaded when cnt_load=1.
- wrap_pulse  out  1  one-cycle pulse, counter wrapped.
- load_err  out  1  one-cycle pulse, LOAD value out of range.
- clear_err  in  1  clears err_flag and err_count.
- err_flag  out  1  sticky, range violation seen.
- err_count  out  ERR_W  saturating number of recoveries.
- running  out  1  high in RUN, or in LOAD/RECOVER when the return state is RUN.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, ret_run=0; all outputs 0.
  - cnt_load_val=0, err_count=0.
  - Reset mid-operation (any state) aborts immediately with the same values.
- illegal = (cnt_value > MAX_COUNT); evaluated only in IDLE and RUN.
- Handshake:
  - cmd_ready = (state==IDLE or RUN) and !illegal; combinational.
  - A command is accepted when cmd_valid and cmd_ready are both 1; it takes effect at that edge.
  - cmd_valid held while cmd_ready=0 is not lost.
- IDLE: cnt_en=0.
  - START -> RUN.
  - LOAD -> LOAD with ret_run=0.
  - STOP and NOP are accepted with no effect.
  - illegal -> RECOVER with ret_run=0.
- RUN: cnt_en=1.
  - STOP -> IDLE.
  - LOAD -> LOAD with ret_run=1.
  - START and NOP: no effect.
  - illegal -> RECOVER with ret_run=1; illegal has priority over any command in the same cycle.
- LOAD: exactly 1 cycle; cnt_en=0, cnt_load=1.
  - cnt_load_val = cmd_data captured at accept if cmd_data <= MAX_COUNT.
  - Otherwise cnt_load_val = 0, and load_err pulses during the LOAD cycle.
  - Exit to RUN if ret_run=1, else IDLE.
- RECOVER: HOLDOFF cycles; cnt_en=0, cnt_load=1, cnt_load_val=0 throughout.
  - On entry: err_flag<=1 and err_count<=err_count+1, saturating at 2^ERR_W-1.
  - Exit to RUN if ret_run=1, else IDLE.
- wrap_pulse:
  - Registered; asserts in the cycle after one where cnt_en=1 and cnt_value==MAX_COUNT.
  - Never asserts from LOAD or RECOVER.
- clear_err:
  - Zeroes err_flag and err_count at the edge.
  - If a RECOVER entry occurs in the same cycle, the error wins: err_flag=1 and err_count=1.
- Counter model assumed by the controller: load has priority over enable, and the counter updates on the same edge.

Test Plan:
- Reset, then START, then 10 enabled cycles from count 0 -> cnt_en=1 from the cycle after accept; wrap_pulse high exactly once, the cycle after cnt_value=9; err_flag=0.
- In RUN, issue LOAD with cmd_data=5 -> one cycle with cnt_load=1, cnt_load_val=5, cmd_ready=0; then RUN resumes; next wrap_pulse follows 5 enabled cycles later.
- In IDLE, issue LOAD with cmd_data=12 -> load_err pulses once; cnt_load_val=0; return to IDLE with cnt_en=0.
- In RUN, force cnt_value=13 -> cmd_ready drops the same cycle; 2 cycles of cnt_load=1 with value 0; err_flag=1, err_count=1; back in RUN with running=1.
- Drive 256 recoveries with ERR_W=8 -> err_count saturates at 255; then pulse clear_err -> err_count=0, err_flag=0. Pulsing clear_err on a RECOVER-entry cycle -> err_count=1.
- Assert rst mid-RECOVER and again mid-LOAD -> next cycle state=IDLE and all outputs 0; a START issued then is accepted normally.
